sc_timing_gen: RTL and testbench
================================

# sc_timing_gen

Sequence counter and timing decoder for the basic-computer control unit. Holds the run flip-flop, the instruction register and the sequence counter SC. It produces the one-hot timing signals T and the opcode decode D consumed by the SC control logic. That logic returns the SC_CLR/SC_INC pair, which this block applies on the next clock edge.

## Interface
- SC_WIDTH, 3, sequence-counter width; T is 2**SC_WIDTH bits wide (8 at default)
- CNT_WIDTH, 16, width of the retired-instruction counter
- CLK  input  1  system clock, all state updates on rising edge
- RST  input  1  reset, synchronous and active-high
- START  input  1  start request; sets the run flip-flop
- HALT  input  1  halt request (HLT execute); clears the run flip-flop
- SC_CLR  input  1  clear SC (from the SC control logic)
- SC_INC  input  1  increment SC (from the SC control logic)
- IR_LD  input  1  load instruction register
- IR_IN  input  16  instruction word from memory bus
- T  output  2**SC_WIDTH  one-hot timing signals, T[i] = (SC==i) while running
- D  output  8  one-hot decode of IR[14:12]
- I_BIT  output  1  IR[15], indirect bit
- SC  output  SC_WIDTH  current sequence-counter value
- RUN  output  1  run flip-flop S
- INSTR_CNT  output  CNT_WIDTH  number of SC clears accepted while running
- ERR  output  1  sticky error: SC_CLR and SC_INC asserted together while running

## Operation
- Reset (RST=1 at edge) forces the following state. The value persists until the first non-reset edge.
  - RUN=0, SC=0, IR=16'h0000, INSTR_CNT=0, ERR=0.
  - Resulting outputs: T=0, D=8'h01, I_BIT=0.
- RST overrides every other input, including mid-instruction.
- Run flip-flop:
  - RUN=0 and START=1: RUN←1 and SC←0.
  - RUN=1 and HALT=1: RUN←0, and SC holds its value.
  - START and HALT both high: HALT wins; RUN←0 when it was 1, and RUN stays 0 when it was 0.
  - START while RUN=1 is ignored.
- Sequence counter, applied only when RUN=1 and HALT=0:
  - SC_CLR=1: SC←0 and INSTR_CNT←INSTR_CNT+1, wrapping at 2**CNT_WIDTH.
  - Else SC_INC=1: SC←SC+1, wrapping from 2**SC_WIDTH−1 to 0. A wrap does not count as a clear.
  - Neither asserted: SC holds.
  - Both asserted: clear wins, and ERR←1. ERR is sticky until RST.
  - When RUN=0, SC_CLR and SC_INC are ignored, and ERR is not set.
- Instruction register:
  - IR←IR_IN on an edge with IR_LD=1, RUN=1 and HALT=0. Otherwise IR holds.
  - IR_LD while stopped is ignored.
- Decode: T, D and I_BIT are combinational from the registered SC, IR and RUN.
  - T is all zero while RUN=0; otherwise exactly one bit of T is high.
  - D is always one-hot, with D[IR[14:12]]=1.

## Timing
- All state changes happen on the rising edge of CLK. Outputs are glitch-free functions of registers only; no input-to-output combinational path exists.
- START sampled at edge k: RUN=1 and T[0]=1 in cycle k+1.
- SC_INC sampled at edge k with SC=n: T[n+1] is asserted in cycle k+1. Latency is one cycle.
- SC_CLR sampled at edge k: T[0] is asserted in cycle k+1, and INSTR_CNT is updated in the same cycle.
- IR_LD sampled at edge k: the new D and I_BIT are valid in cycle k+1.
- HALT sampled at edge k: T=0 from cycle k+1. SC keeps its last value. The next accepted START restarts at T[0].

## Test plan
- Reset and idle:
  - Stimulus: assert RST for 2 cycles, then pulse SC_INC and IR_LD with START=0.
  - Required: T=0, SC=0, RUN=0, D=8'h01, I_BIT=0, INSTR_CNT=0, ERR=0 throughout.
- Start and sequence:
  - Stimulus: START one cycle, then SC_INC held high for 9 cycles.
  - Required: T walks 8'h01, 8'h02 … 8'h80, then wraps to 8'h01. INSTR_CNT stays 0.
- Fetch/decode:
  - Stimulus: while running, IR_LD with IR_IN=16'hB123.
  - Required: next cycle I_BIT=1 and D=8'h08.
  - Follow-up: SC_CLR at SC=5 gives T=8'h01 next cycle and INSTR_CNT=1.
- Conflict:
  - Stimulus: SC_CLR and SC_INC high together at SC=3.
  - Required: SC=0 and ERR=1. ERR stays 1 after further clean cycles and clears only on RST.
- Halt/restart:
  - Stimulus: HALT at SC=4, then SC_INC and IR_LD pulses, then START.
  - Required: T=0 and SC=4 with IR unchanged while stopped. After START, T=8'h01.
  - Also: START and HALT together while running gives RUN=0.
- Reset mid-operation:
  - Stimulus: RST at SC=6 with INSTR_CNT=5.
  - Required: all outputs at their reset values the next cycle.

Source files
------------

// File: rtl/sc_timing_gen.sv
// sc_timing_gen: run flip-flop, instruction register and sequence counter for
// the basic-computer control unit. It produces one-hot timing (T) and opcode
// decode (D). The SC_CLR/SC_INC pair is returned by the SC control logic and
// is applied on the following rising edge.
module sc_timing_gen #(
  parameter int SC_WIDTH  = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic                       HALT,
  input  logic                       SC_CLR,
  input  logic                       SC_INC,
  input  logic                       IR_LD,
  input  logic [15:0]                IR_IN,
  output logic [(2**SC_WIDTH)-1:0]   T,
  output logic [7:0]                 D,
  output logic                       I_BIT,
  output logic [SC_WIDTH-1:0]        SC,
  output logic                       RUN,
  output logic [CNT_WIDTH-1:0]       INSTR_CNT,
  output logic                       ERR
);

  localparam int T_W = 2**SC_WIDTH;

  logic                 run_q, run_d;
  logic [SC_WIDTH-1:0]  sc_q, sc_d;
  logic [15:0]          ir_q, ir_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  // Next-state logic. HALT takes priority over START and over all SC/IR
  // activity. SC_CLR, SC_INC and IR_LD are honoured only while running.
  always_comb begin
    run_d = run_q;
    sc_d  = sc_q;
    ir_d  = ir_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (run_q) begin
      if (HALT) begin
        // Stop. SC keeps its value so the stopped point stays visible.
        run_d = 1'b0;
      end else begin
        if (SC_CLR) begin
          sc_d  = '0;
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (SC_INC) err_d = 1'b1;
        end else if (SC_INC) begin
          // Natural wrap at 2**SC_WIDTH is not counted as a clear.
          sc_d = sc_q + SC_WIDTH'(1);
        end
        if (IR_LD) ir_d = IR_IN;
      end
    end else if (START && !HALT) begin
      run_d = 1'b1;
      sc_d  = '0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      run_q <= 1'b0;
      sc_q  <= '0;
      ir_q  <= 16'h0000;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      run_q <= run_d;
      sc_q  <= sc_d;
      ir_q  <= ir_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Timing and opcode decode. Both are derived from registers only.
  always_comb begin
    T = '0;
    if (run_q) T[sc_q] = 1'b1;
    D = '0;
    D[ir_q[14:12]] = 1'b1;
  end

  assign I_BIT     = ir_q[15];
  assign SC        = sc_q;
  assign RUN       = run_q;
  assign INSTR_CNT = cnt_q;
  assign ERR       = err_q;

  // Unused-width guard: T_W documents the T width derivation.
  logic unused_tw;
  assign unused_tw = (T_W == 0);

endmodule

// File: tb/tb_sc_timing_gen.sv
// Testbench for sc_timing_gen. Each scenario queues stimulus together with the
// expected post-edge outputs. The expected outputs are popped and compared one
// cycle after each drive.
module tb_sc_timing_gen;

  logic        CLK = 1'b0;
  logic        RST = 1'b0, START = 1'b0, HALT = 1'b0;
  logic        SC_CLR = 1'b0, SC_INC = 1'b0, IR_LD = 1'b0;
  logic [15:0] IR_IN = 16'h0000;
  logic [7:0]  T, D;
  logic        I_BIT, RUN, ERR;
  logic [2:0]  SC;
  logic [15:0] INSTR_CNT;

  sc_timing_gen #(.SC_WIDTH(3), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .HALT(HALT),
    .SC_CLR(SC_CLR), .SC_INC(SC_INC), .IR_LD(IR_LD), .IR_IN(IR_IN),
    .T(T), .D(D), .I_BIT(I_BIT), .SC(SC), .RUN(RUN),
    .INSTR_CNT(INSTR_CNT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic rst, start, halt, clr, inc, ld;
    logic [15:0] ir;
  } stim_t;

  typedef struct packed {
    logic [7:0]  t;
    logic [7:0]  d;
    logic        i;
    logic [2:0]  sc;
    logic        run;
    logic [15:0] cnt;
    logic        err;
  } obs_t;

  stim_t stim_q[$];
  obs_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic obs_t mk(input logic [7:0] t, input logic [7:0] d, input logic i,
                              input logic [2:0] sc, input logic run,
                              input logic [15:0] cnt, input logic err);
    obs_t o;
    o.t = t; o.d = d; o.i = i; o.sc = sc; o.run = run; o.cnt = cnt; o.err = err;
    return o;
  endfunction

  function automatic stim_t st(input logic rst, input logic start, input logic halt,
                               input logic clr, input logic inc, input logic ld,
                               input logic [15:0] ir);
    stim_t s;
    s.rst = rst; s.start = start; s.halt = halt; s.clr = clr; s.inc = inc; s.ld = ld; s.ir = ir;
    return s;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.t = T; o.d = D; o.i = I_BIT; o.sc = SC; o.run = RUN; o.cnt = INSTR_CNT; o.err = ERR;
    return o;
  endfunction

  task automatic add(input stim_t s, input obs_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus and sample #1 after the rising edge.
  task automatic cyc(input stim_t s);
    RST = s.rst; START = s.start; HALT = s.halt;
    SC_CLR = s.clr; SC_INC = s.inc; IR_LD = s.ld; IR_IN = s.ir;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, g;
    int   k;
    add(st(1,0,0,0,0,0,16'h0000), mk(8'h00,8'h01,0,3'd0,0,16'd0,0));
    add(st(1,1,0,1,1,1,16'hFFFF), mk(8'h00,8'h01,0,3'd0,0,16'd0,0));
    add(st(0,0,0,0,1,0,16'h0000), mk(8'h00,8'h01,0,3'd0,0,16'd0,0));
    add(st(0,0,0,0,0,1,16'hFFFF), mk(8'h00,8'h01,0,3'd0,0,16'd0,0));
    add(st(0,0,0,1,1,0,16'h0000), mk(8'h00,8'h01,0,3'd0,0,16'd0,0));
    add(st(0,0,0,0,0,0,16'h0000), mk(8'h00,8'h01,0,3'd0,0,16'd0,0));
    k = 0;
    while (stim_q.size() > 0) begin
      cyc(stim_q.pop_front());
      e = exp_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset step %0d: got %h expected %h", k, g, e);
      end
      k++;
    end
  endtask

  task automatic test_sequence();
    obs_t e, g;
    int   k;
    add(st(0,1,0,0,0,0,16'h0000), mk(8'h01,8'h01,0,3'd0,1,16'd0,0));
    for (int n = 1; n <= 9; n++)
      add(st(0,0,0,0,1,0,16'h0000),
          mk(8'h01 << (n % 8), 8'h01, 0, 3'(n % 8), 1, 16'd0, 0));
    k = 0;
    while (stim_q.size() > 0) begin
      cyc(stim_q.pop_front());
      e = exp_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL sequence step %0d: got %h expected %h", k, g, e);
      end
      k++;
    end
  endtask

  // Starts at SC=1 with IR=0. Loads B123, walks SC to 5, then clears.
  task automatic test_fetch();
    obs_t e, g;
    int   k;
    add(st(0,0,0,0,0,1,16'hB123), mk(8'h02,8'h08,1,3'd1,1,16'd0,0));
    add(st(0,0,0,0,1,0,16'h0000), mk(8'h04,8'h08,1,3'd2,1,16'd0,0));
    add(st(0,0,0,0,1,0,16'h0000), mk(8'h08,8'h08,1,3'd3,1,16'd0,0));
    add(st(0,0,0,0,1,0,16'h0000), mk(8'h10,8'h08,1,3'd4,1,16'd0,0));
    add(st(0,0,0,0,1,0,16'h0000), mk(8'h20,8'h08,1,3'd5,1,16'd0,0));
    add(st(0,0,0,1,0,0,16'h0000), mk(8'h01,8'h08,1,3'd0,1,16'd1,0));
    k = 0;
    while (stim_q.size() > 0) begin
      cyc(stim_q.pop_front());
      e = exp_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL fetch step %0d: got %h expected %h", k, g, e);
      end
      k++;
    end
  endtask

  // Starts at SC=0 with INSTR_CNT=1. Ends reset and restarted with IR=0.
  task automatic test_conflict();
    obs_t e, g;
    int   k;
    add(st(0,0,0,0,1,0,16'h0000), mk(8'h02,8'h08,1,3'd1,1,16'd1,0));
    add(st(0,0,0,0,1,0,16'h0000), mk(8'h04,8'h08,1,3'd2,1,16'd1,0));
    add(st(0,0,0,0,1,0,16'h0000), mk(8'h08,8'h08,1,3'd3,1,16'd1,0));
    add(st(0,0,0,1,1,0,16'h0000), mk(8'h01,8'h08,1,3'd0,1,16'd2,1));
    add(st(0,0,0,0,1,0,16'h0000), mk(8'h02,8'h08,1,3'd1,1,16'd2,1));
    add(st(0,0,0,0,0,0,16'h0000), mk(8'h02,8'h08,1,3'd1,1,16'd2,1));
    add(st(1,0,0,0,0,0,16'h0000), mk(8'h00,8'h01,0,3'd0,0,16'd0,0));
    add(st(0,1,0,0,0,0,16'h0000), mk(8'h01,8'h01,0,3'd0,1,16'd0,0));
    k = 0;
    while (stim_q.size() > 0) begin
      cyc(stim_q.pop_front());
      e = exp_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL conflict step %0d: got %h expected %h", k, g, e);
      end
      k++;
    end
  endtask

  // Starts running at SC=0 with IR=0 and INSTR_CNT=0.
  task automatic test_halt_restart();
    obs_t e, g;
    int   k;
    add(st(0,0,0,0,1,1,16'h5000), mk(8'h02,8'h20,0,3'd1,1,16'd0,0));
    add(st(0,0,0,0,1,0,16'h0000), mk(8'h04,8'h20,0,3'd2,1,16'd0,0));
    add(st(0,0,0,0,1,0,16'h0000), mk(8'h08,8'h20,0,3'd3,1,16'd0,0));
    add(st(0,0,0,0,1,0,16'h0000), mk(8'h10,8'h20,0,3'd4,1,16'd0,0));
    add(st(0,0,1,0,1,1,16'hFFFF), mk(8'h00,8'h20,0,3'd4,0,16'd0,0));
    add(st(0,0,0,0,1,0,16'h0000), mk(8'h00,8'h20,0,3'd4,0,16'd0,0));
    add(st(0,0,0,0,0,1,16'hFFFF), mk(8'h00,8'h20,0,3'd4,0,16'd0,0));
    add(st(0,0,0,1,0,0,16'h0000), mk(8'h00,8'h20,0,3'd4,0,16'd0,0));
    add(st(0,1,0,0,0,0,16'h0000), mk(8'h01,8'h20,0,3'd0,1,16'd0,0));
    add(st(0,1,0,0,1,0,16'h0000), mk(8'h02,8'h20,0,3'd1,1,16'd0,0));
    add(st(0,1,1,0,0,0,16'h0000), mk(8'h00,8'h20,0,3'd1,0,16'd0,0));
    add(st(0,1,1,0,0,0,16'h0000), mk(8'h00,8'h20,0,3'd1,0,16'd0,0));
    k = 0;
    while (stim_q.size() > 0) begin
      cyc(stim_q.pop_front());
      e = exp_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL halt_restart step %0d: got %h expected %h", k, g, e);
      end
      k++;
    end
  endtask

  // Starts stopped at SC=1 with IR=5000. Reaches SC=6 and INSTR_CNT=5, then resets.
  task automatic test_reset_mid();
    obs_t e, g;
    int   k;
    add(st(0,1,0,0,0,0,16'h0000), mk(8'h01,8'h20,0,3'd0,1,16'd0,0));
    for (int n = 1; n <= 5; n++)
      add(st(0,0,0,1,0,0,16'h0000), mk(8'h01,8'h20,0,3'd0,1,16'(n),0));
    for (int n = 1; n <= 6; n++)
      add(st(0,0,0,0,1,0,16'h0000), mk(8'h01 << n, 8'h20, 0, 3'(n), 1, 16'd5, 0));
    add(st(1,1,0,1,1,1,16'hFFFF), mk(8'h00,8'h01,0,3'd0,0,16'd0,0));
    add(st(0,0,0,0,0,0,16'h0000), mk(8'h00,8'h01,0,3'd0,0,16'd0,0));
    k = 0;
    while (stim_q.size() > 0) begin
      cyc(stim_q.pop_front());
      e = exp_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset_mid step %0d: got %h expected %h", k, g, e);
      end
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_fetch();
    test_conflict();
    test_halt_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
